// File: rtl/i2c_pkg.sv
// i2c_pkg: shared FSM state type, address constants and R/W bit encodings for the I2C register slave
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK
    } i2c_state_t;

    localparam logic [6:0] I2C_GENCALL_ADDR  = 7'h00;
    localparam logic [4:0] I2C_TENBIT_PREFIX = 5'b11110;
    localparam logic       I2C_RW_WRITE      = 1'b0;
    localparam logic       I2C_RW_READ       = 1'b1;

    // General call and the 10-bit addressing prefix are never acknowledged,
    // even if the own address happens to be configured to one of them.
    function automatic logic i2c_addr_match(input logic [6:0] a, input logic [6:0] own);
        return (a == own) && (a != I2C_GENCALL_ADDR) && (a[6:2] != I2C_TENBIT_PREFIX);
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: two-flop synchronisers for scl/sda plus registered edge, START and STOP detection
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   i_scl, i_sda      raw bus lines
//   o_scl_rise/fall   one-cycle pulses on synchronised scl edges
//   o_start/o_stop    one-cycle pulses on sda fall/rise while scl is high
//   o_sda             synchronised sda aligned with the pulses above
// All pulses appear 3 clk after the raw line change.
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop,
    output logic o_sda
);
    logic r_scl_m, r_scl_s, r_scl_d;
    logic r_sda_m, r_sda_s, r_sda_d;
    logic r_rise, r_fall, r_start, r_stop, r_sda_v;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_scl_m <= 1'b1;
            r_scl_s <= 1'b1;
            r_scl_d <= 1'b1;
            r_sda_m <= 1'b1;
            r_sda_s <= 1'b1;
            r_sda_d <= 1'b1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            r_sda_v <= 1'b1;
        end else begin
            r_scl_m <= i_scl;
            r_scl_s <= r_scl_m;
            r_scl_d <= r_scl_s;
            r_sda_m <= i_sda;
            r_sda_s <= r_sda_m;
            r_sda_d <= r_sda_s;
            r_rise  <= r_scl_s & ~r_scl_d;
            r_fall  <= ~r_scl_s & r_scl_d;
            r_start <= ~r_sda_s & r_sda_d & r_scl_s & r_scl_d;
            r_stop  <= r_sda_s & ~r_sda_d & r_scl_s & r_scl_d;
            r_sda_v <= r_sda_s;
        end
    end

    assign o_scl_rise = r_rise;
    assign o_scl_fall = r_fall;
    assign o_start    = r_start;
    assign o_stop     = r_stop;
    assign o_sda      = r_sda_v;

endmodule

// File: rtl/i2c_reg_slave.sv
// i2c_reg_slave: I2C target exposing DEPTH 8-bit registers behind a pointer byte
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   scl                   I2C clock input (never driven, no stretching)
//   sda                   I2C data, open-drain (drives 0 or z)
//   host_addr/host_rdata  local combinational read port
//   wr_pulse/wr_addr/wr_data  one-cycle strobe and details of each I2C-written byte
//   busy                  high from address ACK until STOP/START
// Config: define I2C_REG_AUTOINC_EN to advance the pointer after every data byte.
module i2c_reg_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] ADDRESS = 7'h50,
    parameter int         DEPTH   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     scl,
    inout  wire                      sda,
    input  logic [$clog2(DEPTH)-1:0] host_addr,
    output logic [7:0]               host_rdata,
    output logic                     wr_pulse,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic [7:0]               wr_data,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);

    i2c_state_t r_state, w_next;
    logic [7:0] r_regs [DEPTH];
    logic [7:0] r_sh;
    logic [3:0] r_cnt;
    logic [AW-1:0] r_ptr, r_wr_addr;
    logic [7:0] r_wr_data;
    logic r_wr_pulse, r_sda_low, r_nack;
    logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda, w_match;
    logic [7:0] w_byte, w_rd_byte;

    i2c_line_sync u_sync (
        .clk        (clk),
        .reset      (reset),
        .i_scl      (scl),
        .i_sda      (sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop),
        .o_sda      (w_sda)
    );

    assign w_byte    = {r_sh[6:0], w_sda};
    assign w_rd_byte = r_regs[r_ptr];
    assign w_match   = i2c_addr_match(r_sh[7:1], ADDRESS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // State advances on scl falling edges, i.e. at bit/ACK boundaries.
    always_comb begin
        w_next = r_state;
        if (w_start) w_next = ADDR;
        else if (w_stop) w_next = IDLE;
        else if (w_scl_fall) begin
            case (r_state)
                ADDR:     if (r_cnt == 4'd8) w_next = w_match ? ADDR_ACK : IDLE;
                ADDR_ACK: w_next = (r_sh[0] == I2C_RW_WRITE) ? PTR : RDATA;
                PTR:      if (r_cnt == 4'd8) w_next = PTR_ACK;
                PTR_ACK:  w_next = WDATA;
                WDATA:    if (r_cnt == 4'd8) w_next = WACK;
                WACK:     w_next = WDATA;
                RDATA:    if (r_cnt == 4'd8) w_next = RACK;
                RACK:     w_next = r_nack ? IDLE : RDATA;
                default:  w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sda_low  <= 1'b0;
            r_cnt      <= '0;
            r_sh       <= '0;
            r_nack     <= 1'b0;
            r_ptr      <= '0;
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else begin
            r_wr_pulse <= 1'b0;
            // Bit counter restarts on every state change so each byte/ACK phase counts from zero.
            if (w_start || w_next != r_state) r_cnt <= '0;
            else if (w_scl_rise && !r_cnt[3]) r_cnt <= r_cnt + 4'd1;
            if (w_scl_rise && (r_state == ADDR || r_state == PTR || r_state == WDATA)) r_sh <= w_byte;
            if (w_scl_rise && r_state == RACK) r_nack <= w_sda;
            if (w_scl_rise && r_state == WDATA && r_cnt == 4'd7) begin
                r_regs[r_ptr] <= w_byte;
                r_wr_pulse    <= 1'b1;
                r_wr_addr     <= r_ptr;
                r_wr_data     <= w_byte;
`ifdef I2C_REG_AUTOINC_EN
                r_ptr         <= r_ptr + 1'b1;
`endif
            end
            // sda drive only changes right after scl falls, so it never creates a false START/STOP.
            if (w_start || w_stop) r_sda_low <= 1'b0;
            else if (w_scl_fall) begin
                case (r_state)
                    ADDR:  r_sda_low <= (r_cnt == 4'd8) && w_match;
                    PTR: begin
                        r_sda_low <= (r_cnt == 4'd8);
                        if (r_cnt == 4'd8) r_ptr <= r_sh[AW-1:0];
                    end
                    WDATA: r_sda_low <= (r_cnt == 4'd8);
                    ADDR_ACK: begin
                        r_sda_low <= (r_sh[0] == I2C_RW_READ) && !w_rd_byte[7];
                        if (r_sh[0] == I2C_RW_READ) r_sh <= w_rd_byte;
                    end
                    RDATA: begin
                        if (r_cnt == 4'd8) begin
                            r_sda_low <= 1'b0;
`ifdef I2C_REG_AUTOINC_EN
                            r_ptr     <= r_ptr + 1'b1;
`endif
                        end else begin
                            r_sh      <= {r_sh[6:0], 1'b0};
                            r_sda_low <= !r_sh[6];
                        end
                    end
                    RACK: begin
                        r_sda_low <= !r_nack && !w_rd_byte[7];
                        if (!r_nack) r_sh <= w_rd_byte;
                    end
                    default: r_sda_low <= 1'b0;
                endcase
            end
        end
    end

    assign sda        = r_sda_low ? 1'b0 : 1'bz;
    assign host_rdata = r_regs[host_addr];
    assign wr_pulse   = r_wr_pulse;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign busy       = !(r_state == IDLE || r_state == ADDR);

endmodule

// File: tb/tb_i2c_reg_slave.sv
// tb_i2c_reg_slave: randomized I2C master driving i2c_reg_slave against a register-map reference model
module tb_i2c_reg_slave;
    localparam int DEPTH = 16;
    localparam int Q = 8;
`ifdef I2C_REG_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic scl = 1'b1;
    logic m_sda = 1'b1;
    wire  sda_bus;
    logic [3:0] host_addr = '0;
    logic [7:0] host_rdata;
    logic wr_pulse, busy;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    int n_checks = 0;
    int n_fail = 0;
    logic [7:0]  m_regs [DEPTH];
    int          m_ptr = 0;
    logic [11:0] exp_q [$];
    logic [11:0] obs_q [$];

    assign sda_bus = m_sda ? 1'bz : 1'b0;
    pullup (sda_bus);

    i2c_reg_slave dut (
        .clk        (clk),
        .reset      (reset),
        .scl        (scl),
        .sda        (sda_bus),
        .host_addr  (host_addr),
        .host_rdata (host_rdata),
        .wr_pulse   (wr_pulse),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (!reset && wr_pulse) obs_q.push_back({wr_addr, wr_data});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        m_sda = 1'b1; wq(Q);
        scl = 1'b1;   wq(Q);
        m_sda = 1'b0; wq(Q);
        scl = 1'b0;   wq(Q);
    endtask

    task automatic do_stop();
        m_sda = 1'b0; wq(Q);
        scl = 1'b1;   wq(Q);
        m_sda = 1'b1; wq(Q);
    endtask

    task automatic put_bit(input logic b);
        m_sda = b;  wq(Q);
        scl = 1'b1; wq(2 * Q);
        scl = 1'b0; wq(Q);
    endtask

    task automatic get_bit(output logic b);
        m_sda = 1'b1; wq(Q);
        scl = 1'b1;   wq(Q);
        b = sda_bus;  wq(Q);
        scl = 1'b0;   wq(Q);
    endtask

    task automatic put_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
        get_bit(ack);
    endtask

    task automatic get_byte(output logic [7:0] v, input logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            v[i] = b;
        end
        put_bit(ack);
    endtask

    task automatic compare_writes(input string tag);
        check({tag, "_npulse"}, obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_wr"}, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic compare_regs(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            host_addr = 4'(a);
            #1;
            check({tag, "_reg"}, host_rdata, m_regs[a]);
        end
    endtask

    task automatic model_write(input logic [6:0] a, input logic [7:0] p, input int n, input logic [23:0] ds);
        logic ack;
        logic [7:0] d;
        bit match;
        match = (a == 7'h50);
        do_start();
        put_byte({a, 1'b0}, ack);
        check("waddr_ack", ack, !match);
        check("waddr_busy", busy, match);
        if (match) begin
            put_byte(p, ack);
            check("ptr_ack", ack, 0);
            m_ptr = p % DEPTH;
            for (int k = 0; k < n; k++) begin
                d = ds[8*k +: 8];
                put_byte(d, ack);
                check("wdata_ack", ack, 0);
                m_regs[m_ptr] = d;
                exp_q.push_back({m_ptr[3:0], d});
                if (AUTOINC) m_ptr = (m_ptr + 1) % DEPTH;
            end
        end
        do_stop();
        check("wr_stop_busy", busy, 0);
        compare_writes("write");
    endtask

    task automatic model_read(input bit set_ptr, input logic [7:0] p, input int n);
        logic ack;
        logic [7:0] v;
        if (set_ptr) begin
            do_start();
            put_byte(8'hA0, ack);
            check("rptr_addr_ack", ack, 0);
            put_byte(p, ack);
            check("rptr_ack", ack, 0);
            m_ptr = p % DEPTH;
        end
        do_start();
        put_byte(8'hA1, ack);
        check("raddr_ack", ack, 0);
        check("rd_busy", busy, 1);
        for (int k = 0; k < n; k++) begin
            get_byte(v, k == n - 1);
            check("rdata", v, m_regs[m_ptr]);
            if (AUTOINC) m_ptr = (m_ptr + 1) % DEPTH;
        end
        check("rd_nack_idle", busy, 0);
        do_stop();
        compare_writes("read");
    endtask

    initial begin
        logic ack;
        for (int a = 0; a < DEPTH; a++) m_regs[a] = 8'h00;
        wq(5);
        check("rst_sda", sda_bus, 1);
        check("rst_busy", busy, 0);
        check("rst_pulse", wr_pulse, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        reset = 1'b0;
        wq(5);
        compare_regs("rst");

        // basic write with fixed values
        model_write(7'h50, 8'h03, 1, 24'h0000A5);
        check("w_wr_addr", wr_addr, 3);
        check("w_wr_data", wr_data, 8'hA5);
        host_addr = 4'd3;
        #1;
        check("w_host_rdata", host_rdata, 8'hA5);

        // wrong address is not acknowledged
        model_write(7'h51, 8'h00, 0, 24'h0);
        model_write(7'h00, 8'h00, 0, 24'h0);

        // two consecutive data bytes
        model_write(7'h50, 8'h02, 2, 24'h002211);
        compare_regs("two_bytes");

        // fill every register with random data
        for (int a = 0; a < DEPTH; a++) model_write(7'h50, 8'(a), 1, 24'($urandom));
        compare_regs("fill");

        // pointer then repeated start read across the wrap point
        model_read(1'b1, 8'h0F, 2);

        // STOP in the middle of a data byte
        m_ptr = 6;
        do_start();
        put_byte(8'hA0, ack);
        check("abort_addr_ack", ack, 0);
        put_byte(8'hF6, ack);
        check("abort_ptr_ack", ack, 0);
        for (int i = 0; i < 4; i++) put_bit(1'($urandom));
        do_stop();
        check("abort_busy", busy, 0);
        compare_writes("abort");
        compare_regs("abort");

        // randomized traffic
        for (int t = 0; t < 20; t++) begin
            int kind;
            logic [6:0] a;
            kind = $urandom_range(0, 5);
            a = 7'h50;
            if (kind == 5) begin
                a = 7'($urandom);
                if (a == 7'h50) a = 7'h51;
            end
            if (kind <= 1 || kind == 5) model_write(a, 8'($urandom), $urandom_range(0, 3), 24'($urandom));
            else model_read(kind != 4, 8'($urandom), $urandom_range(1, 3));
        end
        compare_regs("random");

        // reset while the target is driving a 0 data bit
        model_write(7'h50, 8'h05, 1, 24'h00003C);
        do_start();
        put_byte(8'hA0, ack);
        put_byte(8'h05, ack);
        do_start();
        put_byte(8'hA1, ack);
        check("mid_rd_ack", ack, 0);
        check("mid_rd_drive", sda_bus, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_release", sda_bus, 1);
        wq(3);
        reset = 1'b0;
        wq(2);
        for (int a = 0; a < DEPTH; a++) m_regs[a] = 8'h00;
        m_ptr = 0;
        obs_q.delete();
        exp_q.delete();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_wr_addr", wr_addr, 0);
        compare_regs("mid_rst");
        put_byte(8'hA0, ack);
        check("no_start_nack", ack, 1);
        check("no_start_busy", busy, 0);
        do_stop();
        model_write(7'h50, 8'h02, 1, 24'h00005A);
        model_read(1'b0, 8'h00, 1);
        compare_regs("final");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
